alu_step_sequencer: RTL and testbench

- Hardwired control-step generator for register-to-register ALU instructions on the single-bus datapath.
- Per instruction, sequences fetch (T0–T2), operand staging (T3), execute (T4) and writeback (T5, plus T6 for MUL/DIV).
- Drives the datapath's existing in/out/op_code control pins, replacing hand-timed testbench stimulus.
- Successor to fixed-width, fixed-sequence stepping: parametrised in width and register count, with memory-ready and ALU-done handshakes and a HI/LO writeback path.

---
 rtl/alu_seq_pkg.sv | 49 ++++
 rtl/alu_step_sequencer_reg_sel_decoder.sv | 13 +
 rtl/alu_step_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_alu_step_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types, opcode map and IR field layout for the ALU step sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    localparam int OPC_DEF_W = 5;

    localparam logic [OPC_DEF_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_DEF_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_DEF_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_DEF_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_DEF_W-1:0] OPC_ROR  = 5'b00111;
    localparam logic [OPC_DEF_W-1:0] OPC_ROL  = 5'b01000;
    localparam logic [OPC_DEF_W-1:0] OPC_SHR  = 5'b01001;
    localparam logic [OPC_DEF_W-1:0] OPC_SHRA = 5'b01010;
    localparam logic [OPC_DEF_W-1:0] OPC_SHL  = 5'b01011;
    localparam logic [OPC_DEF_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_DEF_W-1:0] OPC_DIV  = 5'b10000;

    function automatic logic is_long_op(input logic [OPC_DEF_W-1:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

    function automatic logic is_alu_op(input logic [OPC_DEF_W-1:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR, OPC_ROL,
            OPC_SHR, OPC_SHRA, OPC_SHL:  return 1'b1;
            default:                     return is_long_op(opc);
        endcase
    endfunction

    // IR layout from the MSB down: opcode, ra, rb, rc, then unused low bits.
    function automatic int opc_lsb(input int data_w, input int opc_w);
        return data_w - opc_w;
    endfunction

    function automatic int ra_lsb(input int data_w, input int opc_w, input int ridx_w);
        return data_w - opc_w - ridx_w;
    endfunction

    function automatic int rb_lsb(input int data_w, input int opc_w, input int ridx_w);
        return data_w - opc_w - 2 * ridx_w;
    endfunction

    function automatic int rc_lsb(input int data_w, input int opc_w, input int ridx_w);
        return data_w - opc_w - 3 * ridx_w;
    endfunction

endpackage

// File: rtl/alu_step_sequencer_reg_sel_decoder.sv
// Register index to one-hot select, gated by an enable.
module reg_sel_decoder #(
    parameter int NUM_REGS = 16,
    parameter int RIDX_W   = $clog2(NUM_REGS)
) (
    input  logic                en,
    input  logic [RIDX_W-1:0]   idx,
    output logic [NUM_REGS-1:0] sel
);
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sel
        assign sel[i] = en && (idx == RIDX_W'(i));
    end
endmodule

// File: rtl/alu_step_sequencer.sv
// Hardwired control-step sequencer for register-to-register ALU instructions.
// Optional macro SINGLE_STEP_EN adds a step input gating every T0-T6 transition.
module alu_step_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int OPC_W       = 5,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                clr,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic                start,
    input  logic [DATA_W-1:0]   ir_q,
    input  logic                mem_rdy,
    input  logic                alu_done,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                pc_out,
    output logic                pc_increment,
    output logic                mar_in,
    output logic                pc_in,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                zhigh_in,
    output logic                zlow_in,
    output logic                zhigh_out,
    output logic                zlow_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic [OPC_W-1:0]    op_code
);
    localparam int RIDX_W  = $clog2(NUM_REGS);
    localparam int CNT_W   = $clog2(ALU_TIMEOUT + 1);
    localparam int OPC_LSB = opc_lsb(DATA_W, OPC_W);
    localparam int RA_LSB  = ra_lsb(DATA_W, OPC_W, RIDX_W);
    localparam int RB_LSB  = rb_lsb(DATA_W, OPC_W, RIDX_W);
    localparam int RC_LSB  = rc_lsb(DATA_W, OPC_W, RIDX_W);

    state_t            state, next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              adv, fin, abort, cnt_inc;
    logic              rin_en, rout_en;
    logic [RIDX_W-1:0] rout_idx;
    logic              done_q, illegal_q;

    logic [OPC_W-1:0]  opcode;
    logic [RIDX_W-1:0] ra, rb, rc;
    logic              legal, long_op, timeout_hit;

    assign opcode  = ir_q[OPC_LSB +: OPC_W];
    assign ra      = ir_q[RA_LSB +: RIDX_W];
    assign rb      = ir_q[RB_LSB +: RIDX_W];
    assign rc      = ir_q[RC_LSB +: RIDX_W];
    assign legal   = is_alu_op(OPC_DEF_W'(opcode));
    assign long_op = is_long_op(OPC_DEF_W'(opcode));

    if (RC_LSB > 0) begin : g_unused
        logic unused_ir;
        assign unused_ir = ^ir_q[RC_LSB-1:0];
    end

`ifdef SINGLE_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    // The last permitted wait cycle is the one where the count reads ALU_TIMEOUT-1.
    assign timeout_hit = (wait_cnt == CNT_W'(ALU_TIMEOUT - 1));

    always_comb begin
        next_state   = state;
        fin          = 1'b0;
        abort        = 1'b0;
        cnt_inc      = 1'b0;
        rin_en       = 1'b0;
        rout_en      = 1'b0;
        rout_idx     = rb;
        pc_out       = 1'b0;
        pc_increment = 1'b0;
        mar_in       = 1'b0;
        pc_in        = 1'b0;
        read         = 1'b0;
        mdr_in       = 1'b0;
        mdr_out      = 1'b0;
        ir_in        = 1'b0;
        y_in         = 1'b0;
        zhigh_in     = 1'b0;
        zlow_in      = 1'b0;
        zhigh_out    = 1'b0;
        zlow_out     = 1'b0;
        hi_in        = 1'b0;
        lo_in        = 1'b0;
        op_code      = '0;
        case (state)
            IDLE: if (start) next_state = T0;
            T0: begin
                pc_out       = 1'b1;
                pc_increment = 1'b1;
                mar_in       = 1'b1;
                zlow_in      = 1'b1;
                zhigh_in     = 1'b1;
                if (adv) next_state = T1;
            end
            T1: begin
                zlow_out = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
                // PC loads only on the leaving cycle so a memory stall cannot bump it twice.
                if (mem_rdy && adv) begin
                    pc_in      = 1'b1;
                    next_state = T2;
                end
            end
            T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                if (adv) next_state = T3;
            end
            T3: begin
                if (legal) begin
                    rout_en = 1'b1;
                    y_in    = 1'b1;
                    if (adv) next_state = T4;
                end else if (adv) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                op_code  = opcode;
                if (!long_op) begin
                    zlow_in  = 1'b1;
                    zhigh_in = 1'b1;
                    if (adv) next_state = T5;
                end else if (adv) begin
                    if (alu_done) begin
                        zlow_in    = 1'b1;
                        zhigh_in   = 1'b1;
                        next_state = T5;
                    end else if (timeout_hit) begin
                        next_state = IDLE;
                        abort      = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            T5: begin
                zlow_out = 1'b1;
                lo_in    = long_op;
                rin_en   = !long_op;
                if (adv) begin
                    next_state = long_op ? T6 : IDLE;
                    fin        = !long_op;
                end
            end
            T6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                if (adv) begin
                    next_state = IDLE;
                    fin        = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state     <= next_state;
            done_q    <= fin || abort;
            illegal_q <= abort;
            if (state != T4)  wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = done_q;
    assign illegal = illegal_q;

    reg_sel_decoder #(.NUM_REGS(NUM_REGS), .RIDX_W(RIDX_W)) u_rin_dec (
        .en  (rin_en),
        .idx (ra),
        .sel (r_in)
    );

    reg_sel_decoder #(.NUM_REGS(NUM_REGS), .RIDX_W(RIDX_W)) u_rout_dec (
        .en  (rout_en),
        .idx (rout_idx),
        .sel (r_out)
    );

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench: per-cycle control trace model plus a small datapath model for writeback values.
module tb_alu_step_sequencer;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int OW = 5;

    localparam logic [OW-1:0] C_ADD = 5'b00011;
    localparam logic [OW-1:0] C_SHL = 5'b01011;
    localparam logic [OW-1:0] C_MUL = 5'b01111;
    localparam logic [OW-1:0] C_DIV = 5'b10000;
    localparam logic [OW-1:0] C_BAD = 5'b11111;

    logic clk = 1'b0;
    logic clr, start, mem_rdy, alu_done, dp_init;
    logic [DW-1:0] ir_q;
    logic busy, done, illegal, pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out;
    logic ir_in, y_in, zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in;
    logic [NR-1:0] r_in, r_out;
    logic [OW-1:0] op_code;
`ifdef SINGLE_STEP_EN
    logic step;
`endif

    always #5 clk = ~clk;

    alu_step_sequencer dut (
        .clk(clk), .clr(clr),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .start(start), .ir_q(ir_q), .mem_rdy(mem_rdy), .alu_done(alu_done),
        .busy(busy), .done(done), .illegal(illegal),
        .pc_out(pc_out), .pc_increment(pc_increment), .mar_in(mar_in), .pc_in(pc_in),
        .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
        .zhigh_in(zhigh_in), .zlow_in(zlow_in), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .hi_in(hi_in), .lo_in(lo_in), .r_in(r_in), .r_out(r_out), .op_code(op_code)
    );

    typedef struct packed {
        logic busy, done, illegal, pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out;
        logic ir_in, y_in, zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in;
        logic [NR-1:0] r_in, r_out;
        logic [OW-1:0] op_code;
    } ctl_t;

    typedef struct {
        logic start, mem_rdy, alu_done, clr, step;
        ctl_t exp;
    } ent_t;

    ctl_t act;
    assign act = {busy, done, illegal, pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out,
                  ir_in, y_in, zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in,
                  r_in, r_out, op_code};

    ent_t q[$];
    int ncmp = 0;
    int nerr = 0;

    // Bench-side single-bus datapath driven by the DUT's controls.
    logic [DW-1:0] regs [NR];
    logic [DW-1:0] pc, mdr, y, lo, hi, bus;
    logic [2*DW-1:0] z;

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [2*DW-1:0] alu(input logic [OW-1:0] opc, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (opc)
            C_ADD:   return {32'b0, a + b};
            C_SHL:   return {32'b0, a << b[4:0]};
            C_MUL:   return {32'b0, a} * {32'b0, b};
            C_DIV:   return {a % b, a / b};
            default: return '0;
        endcase
    endfunction

    always_comb begin
        bus = '0;
        if (pc_out)         bus = pc;
        else if (zlow_out)  bus = z[DW-1:0];
        else if (zhigh_out) bus = z[2*DW-1:DW];
        else if (mdr_out)   bus = mdr;
        else if (|r_out)    bus = regs[oh_idx(r_out)];
    end

    always @(posedge clk) begin
        if (dp_init) begin
            for (int i = 0; i < NR; i++) regs[i] <= 32'hA0A0_0000 + i;
            regs[3] <= 32'h000D_61FE;
            regs[7] <= 32'd5;
            regs[2] <= 32'h1234_5678;
            regs[5] <= 32'h0000_0100;
            pc <= 32'h100; mdr <= '0; y <= '0; z <= '0; lo <= '0; hi <= '0;
        end else begin
            if (pc_in)          pc <= bus;
            if (read && mdr_in) mdr <= ir_q;
            if (y_in)           y <= bus;
            if (zlow_in)        z <= pc_increment ? {32'b0, bus + 32'd1} : alu(op_code, y, bus);
            if (|r_in)          regs[oh_idx(r_in)] <= bus;
            if (lo_in)          lo <= bus;
            if (hi_in)          hi <= bus;
        end
    end

    function automatic logic legal(input logic [OW-1:0] opc);
        return opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                           5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000};
    endfunction

    task automatic push(input logic s, input logic m, input logic a, input logic c, input logic st, input ctl_t e);
        ent_t n;
        n.start = s; n.mem_rdy = m; n.alu_done = a; n.clr = c; n.step = st; n.exp = e;
        q.push_back(n);
    endtask

    // Expected per-cycle control trace for one instruction, from the step table.
    task automatic build(input logic [OW-1:0] opc, input int ra, input int rb, input int rc,
                         input int mem_wait, input int alu_wait, input bit tmo, input bit clr_t4,
                         input int step_hold);
        ctl_t c;
        bit lng;
        lng = (opc == C_MUL) || (opc == C_DIV);
        ir_q = {opc, 4'(ra), 4'(rb), 4'(rc), 15'b0};
        c = '0; push(1, 0, 0, 0, 1, c);
        c = '0; c.busy = 1; c.pc_out = 1; c.pc_increment = 1; c.mar_in = 1; c.zlow_in = 1; c.zhigh_in = 1;
        push(0, 0, 0, 0, 1, c);
        c = '0; c.busy = 1; c.zlow_out = 1; c.read = 1; c.mdr_in = 1;
        repeat (mem_wait) push(0, 0, 0, 0, 1, c);
        c.pc_in = 1; push(0, 1, 0, 0, 1, c);
        c = '0; c.busy = 1; c.mdr_out = 1; c.ir_in = 1;
        repeat (step_hold) push(0, 0, 0, 0, 0, c);
        push(0, 0, 0, 0, 1, c);
        if (!legal(opc)) begin
            c = '0; c.busy = 1; push(0, 0, 0, 0, 1, c);
            c = '0; c.done = 1; c.illegal = 1; push(0, 0, 0, 0, 1, c);
            return;
        end
        c = '0; c.busy = 1; c.r_out = NR'(1) << rb; c.y_in = 1; push(0, 0, 0, 0, 1, c);
        c = '0; c.busy = 1; c.r_out = NR'(1) << rc; c.op_code = opc;
        if (!lng) begin
            c.zlow_in = 1; c.zhigh_in = 1;
            push(0, 0, 0, clr_t4, 1, c);
            if (clr_t4) begin
                c = '0; push(0, 0, 0, 0, 1, c);
                return;
            end
        end else if (tmo) begin
            repeat (64) push(0, 0, 0, 0, 1, c);
            c = '0; c.done = 1; c.illegal = 1; push(0, 0, 0, 0, 1, c);
            return;
        end else begin
            repeat (alu_wait) push(0, 0, 0, 0, 1, c);
            c.zlow_in = 1; c.zhigh_in = 1; push(0, 0, 1, 0, 1, c);
        end
        c = '0; c.busy = 1; c.zlow_out = 1;
        if (lng) c.lo_in = 1; else c.r_in = NR'(1) << ra;
        push(0, 0, 0, 0, 1, c);
        if (lng) begin
            c = '0; c.busy = 1; c.zhigh_out = 1; c.hi_in = 1; push(0, 0, 0, 0, 1, c);
        end
        c = '0; c.done = 1; push(0, 0, 0, 0, 1, c);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drives each queued cycle and compares the DUT's controls against the trace.
    task automatic play(input string nm, output int lat, output int n_pcin, output int n_hilo, output int n_rin);
        ent_t e;
        int idx, st;
        idx = 0; st = -1; lat = -1; n_pcin = 0; n_hilo = 0; n_rin = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            start = e.start; mem_rdy = e.mem_rdy; alu_done = e.alu_done; clr = e.clr;
`ifdef SINGLE_STEP_EN
            step = e.step;
`endif
            @(negedge clk);
            ncmp++;
            if (act !== e.exp) begin
                nerr++;
                $display("FAIL %s cycle %0d ctl: got %h expected %h", nm, idx, act, e.exp);
            end
            if (e.start && st < 0) st = idx;
            if (done === 1'b1 && lat < 0 && st >= 0) lat = idx - st;
            if (pc_in === 1'b1) n_pcin++;
            if (hi_in === 1'b1 || lo_in === 1'b1) n_hilo++;
            if (|r_in) n_rin++;
            idx++;
        end
        @(posedge clk); #1;
        start = 0; mem_rdy = 0; alu_done = 0; clr = 0;
`ifdef SINGLE_STEP_EN
        step = 1;
`endif
    endtask

    initial begin
        int lat, npc, nhl, nri;
        logic [DW-1:0] pc0;
        clr = 1; dp_init = 1; start = 0; mem_rdy = 0; alu_done = 0; ir_q = '0;
`ifdef SINGLE_STEP_EN
        step = 1;
`endif
        repeat (2) @(posedge clk);
        #1 clr = 0; dp_init = 0;

        build(C_SHL, 4, 3, 7, 0, 0, 0, 0, 0);
        pc0 = pc;
        play("shl", lat, npc, nhl, nri);
        check("shl_latency", lat, 7);
        check("shl_r4", regs[4], 32'h01AC_3FC0);
        check("shl_pc_step", pc, pc0 + 1);

        build(C_ADD, 8, 3, 7, 3, 0, 0, 0, 0);
        pc0 = pc;
        play("add_memwait", lat, npc, nhl, nri);
        check("memwait_latency", lat, 10);
        check("memwait_pc_in_count", npc, 1);
        check("memwait_pc_step", pc, pc0 + 1);
        check("add_r8", regs[8], 32'h000D_6203);

        build(C_MUL, 1, 2, 5, 0, 9, 0, 0, 0);
        play("mul", lat, npc, nhl, nri);
        check("mul_latency", lat, 17);
        check("mul_lo", lo, 32'h3456_7800);
        check("mul_hi", hi, 32'h0000_0012);
        check("mul_r_in_count", nri, 0);

        build(C_BAD, 10, 3, 7, 0, 0, 0, 0, 0);
        play("illegal", lat, npc, nhl, nri);
        check("illegal_latency", lat, 5);
        check("illegal_r10_kept", regs[10], 32'hA0A0_000A);

        build(C_DIV, 12, 2, 5, 0, 0, 1, 0, 0);
        play("div_timeout", lat, npc, nhl, nri);
        check("timeout_latency", lat, 69);
        check("timeout_hilo_count", nhl, 0);
        check("timeout_r12_kept", regs[12], 32'hA0A0_000C);

        build(C_SHL, 9, 3, 7, 0, 0, 0, 1, 0);
        play("clr_in_t4", lat, npc, nhl, nri);
        check("clr_no_done", lat, -1);
        check("clr_r9_kept", regs[9], 32'hA0A0_0009);

        build(C_SHL, 6, 3, 7, 0, 0, 0, 0, 0);
        play("after_clr", lat, npc, nhl, nri);
        check("after_clr_latency", lat, 7);
        check("after_clr_r6", regs[6], 32'h01AC_3FC0);

`ifdef SINGLE_STEP_EN
        build(C_SHL, 11, 3, 7, 0, 0, 0, 0, 3);
        play("step_hold", lat, npc, nhl, nri);
        check("step_latency", lat, 10);
        check("step_r11", regs[11], 32'h01AC_3FC0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
